// File: rtl/ahb_lite_req_master.sv
// AHB-lite single-transfer master driven by a valid/ready request port.
// Handles wait states, ERROR responses, lane steering, alignment and timeout.
module ahb_lite_req_master #(
  parameter int ADDR_WIDTH = 15,
  parameter int TIMEOUT    = 255
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  hsel,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [1:0]            htrans,
  output logic [31:0]           hwdata,
  input  logic [31:0]           hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_t                state_q, state_d;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic [31:0]           wdata_q;
  logic [15:0]           wcnt_q, wcnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  aligned;
  logic                  to_hit;
  logic [31:0]           lane_wdata;
  logic [31:0]           lane_rdata;

  assign accept = req_valid && req_ready;
  assign to_hit = (TIMEOUT != 0) && (wcnt_q + 16'd1 == TO_LIM);

  always_comb begin
    aligned = 1'b0;
    unique case (1'b1)
      req_size == 2'd0: aligned = 1'b1;
      req_size == 2'd1: aligned = !req_addr[0];
      req_size == 2'd2: aligned = req_addr[1:0] == 2'b00;
      default:          aligned = 1'b0;
    endcase
  end

  always_comb begin
    lane_wdata = wdata_q;
    unique case (1'b1)
      size_q == 2'd0: lane_wdata = {4{wdata_q[7:0]}};
      size_q == 2'd1: lane_wdata = {2{wdata_q[15:0]}};
      default:        lane_wdata = wdata_q;
    endcase
  end

  always_comb begin
    lane_rdata = hrdata;
    unique case (1'b1)
      size_q == 2'd0:
        lane_rdata = {24'd0, hrdata[{addr_q[1:0], 3'b000} +: 8]};
      size_q == 2'd1:
        lane_rdata = {16'd0, hrdata[{addr_q[1], 4'b0000} +: 16]};
      default:
        lane_rdata = hrdata;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'd0;
      wdata_q <= 32'd0;
      wcnt_q  <= 16'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
      end
    end
  end

  // A completing edge wins over a timeout landing on the same edge
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (aligned) begin
            state_d = S_ADDR;
          end else begin
            state_d = S_RESP;
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (hready) begin
          state_d = S_DATA;
          wcnt_d  = 16'd0;
        end
      end
      S_DATA: begin
        if (hready) begin
          state_d = S_RESP;
          err_d   = hresp;
          rdata_d = wr_q ? 32'd0 : lane_rdata;
        end else if (to_hit) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    hsel      = 1'b0;
    haddr     = '0;
    hwrite    = 1'b0;
    hsize     = 3'd0;
    htrans    = 2'b00;
    hwdata    = 32'd0;
    unique case (state_q)
      S_IDLE: req_ready = hresetn;
      S_ADDR: begin
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = addr_q;
        hwrite = wr_q;
        hsize  = {1'b0, size_q};
      end
      S_DATA: hwdata = wr_q ? lane_wdata : 32'd0;
      S_RESP: rsp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/ahb_lite_req_master.md
Name: ahb_lite_req_master

Overview:
- Upstream AHB-lite master stage that turns a simple valid/ready request port into single, non-burst AHB-lite transfers.
- Drives the on-chip RAM slave and any other AHB-lite slave on the local bus.
- Handles wait states, two-cycle ERROR responses, byte-lane steering, alignment checking and a data-phase timeout.
- Returns exactly one response per accepted request.

Parameters:
- ADDR_WIDTH, 15, width of req_addr and haddr.
- TIMEOUT, 255, maximum data-phase cycles with hready low before abort; 0 disables the timeout; legal range 0..65535.

Ports:
- hclk  input  1  bus clock; all logic is on the rising edge.
- hresetn  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted on an edge where req_valid and req_ready are both 1.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  byte address.
- req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal.
- req_wdata  input  32  write data, right-justified.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  read data, right-justified and zero-extended.
- rsp_err  output  1  error flag, qualified by rsp_valid.
- hsel  output  1  slave select.
- haddr  output  ADDR_WIDTH  AHB address.
- hwrite  output  1  AHB write.
- hsize  output  3  AHB size, {1'b0, size}.
- htrans  output  2  AHB transfer type; 2'b00 IDLE, 2'b10 NONSEQ.
- hwdata  output  32  AHB write data.
- hrdata  input  32  AHB read data.
- hready  input  1  AHB transfer done / wait.
- hresp  input  1  AHB error response.

Behaviour:
- Reset (asynchronous, hresetn low): state IDLE; all outputs 0 except req_ready, which is 1 once out of reset. No response is issued for a transfer cut by reset.
- States are IDLE, ADDR, DATA, RESP.
- IDLE:
  - req_ready=1, htrans=00, hsel=0.
  - On acceptance, register write/addr/size/wdata.
  - Legal and aligned request (size 0 any address; size 1 with addr[0]=0; size 2 with addr[1:0]=0): go to ADDR.
  - Otherwise go to RESP with rsp_err=1 and rsp_rdata=0. No bus cycle is issued.
- ADDR:
  - Drive hsel=1, htrans=10, haddr, hwrite and hsize from the registers; req_ready=0.
  - On an edge with hready=1, go to DATA. While hready=0, hold all address-phase outputs stable.
- DATA:
  - htrans=00 and hsel=0; hwdata holds the lane-steered write data (0 for reads). Write-data replication: byte {4{d[7:0]}}, halfword {2{d[15:0]}}, word d.
  - On an edge with hready=1, capture the response and go to RESP:
    - rsp_err=hresp.
    - Read data: byte = hrdata[8*addr[1:0] +: 8], halfword = hrdata[16*addr[1] +: 16], word = hrdata. All zero-extended.
    - Writes return rsp_rdata=0.
  - hresp=1 with hready=0 (first ERROR cycle) keeps the block in DATA. The error is taken on the completing edge.
  - A 16-bit wait counter clears on entry to DATA and increments on each edge with hready=0. If TIMEOUT!=0 and the counter reaches TIMEOUT, go to RESP with rsp_err=1 and rsp_rdata=0; later bus activity for that transfer is ignored.
- RESP:
  - rsp_valid=1 for exactly one cycle; go to IDLE on the next edge. req_ready=0 in RESP.
- Latency:
  - Zero-wait transfer: accept at edge 0, ADDR in cycle 1, DATA in cycle 2, rsp_valid in cycle 3. Each hready-low cycle adds one cycle.
  - Misaligned request: rsp_valid in cycle 1.
- Throughput: one outstanding transfer; no address/data pipelining; a new request is accepted at the earliest at the edge ending RESP.
- rsp_rdata and rsp_err hold their values until the next response. rsp_valid has no backpressure.

Test Plan:
- Zero-wait word write, addr 0x0010, wdata 0xDEADBEEF -> htrans=10 with hsize=010 in cycle 1; hwdata=0xDEADBEEF in cycle 2; rsp_valid=1, rsp_err=0 in cycle 3.
- Byte read at addr 0x0013 with slave hrdata 0xA1B2C3D4 -> rsp_rdata=0x000000A1. Halfword write 0x1234 at 0x0002 -> hwdata=0x12341234, hsize=001.
- Slave holds hready low for 3 DATA cycles -> address-phase outputs stay idle, rsp_valid in cycle 6, and exactly one response.
- Two-cycle ERROR (hresp=1/hready=0, then hresp=1/hready=1) -> rsp_err=1, rsp_valid in the following cycle. Word request at 0x0006 -> no htrans activity, rsp_err=1 in cycle 1.
- TIMEOUT=4 with hready stuck low in DATA -> rsp_err=1 after 4 wait edges; state returns to IDLE; req_ready=1 in the cycle after RESP.
- hresetn pulsed low during DATA -> outputs 0 immediately, no rsp_valid; a fresh request after reset completes normally.
